// File: rtl/dlfloat_dot_ctrl.sv
// DLFloat16 dot-product sequencer: feeds operand pairs to the shared MAC, waits out its pipeline, returns the sum.
// Optional build macro DLMAC_ZERO_SKIP_EN: beats with a zero operand are not issued (except a vector's first beat).
module dlfloat_dot_ctrl #(
  parameter int MAC_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  output logic             mac_en,
  output logic             mac_first,
  input  logic [15:0]      mac_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_nan,
  output logic [CNT_W-1:0] out_cnt
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid holds its payload until then.

  localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic             nan_q, nan_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [15:0]      mac_a_d, mac_b_d;
  logic             mac_en_d, mac_first_d;
  logic             out_valid_d, out_nan_d;
  logic [15:0]      out_data_d;
  logic [CNT_W-1:0] out_cnt_d;
  logic             accept;
  logic             issue;

  assign in_ready = (state_q == ACC);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    nan_d       = nan_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    mac_a_d     = mac_a;
    mac_b_d     = mac_b;
    mac_en_d    = 1'b0;
    mac_first_d = 1'b0;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_nan_d   = out_nan;
    out_cnt_d   = out_cnt;
`ifdef DLMAC_ZERO_SKIP_EN
    // The first beat is always issued so the accumulator gets cleared.
    issue = first_q || ((in_a != 16'h0000) && (in_b != 16'h0000));
`else
    issue = 1'b1;
`endif
    unique case (state_q)
      ACC: begin
        if (accept) begin
          mac_a_d     = in_a;
          mac_b_d     = in_b;
          mac_en_d    = issue;
          mac_first_d = first_q && issue;
          first_d     = 1'b0;
          cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          nan_d       = nan_q || (in_a == 16'hFFFF) || (in_b == 16'hFFFF);
          if (in_last) begin
            state_d = DRAIN;
            drain_d = DW'(MAC_LAT);
          end
        end
      end
      DRAIN: begin
        if (drain_q != '0) begin
          drain_d = drain_q - 1'b1;
        end else begin
          out_data_d  = mac_result;
          out_nan_d   = nan_q;
          out_cnt_d   = cnt_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          nan_d       = 1'b0;
          first_d     = 1'b1;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      first_q   <= 1'b1;
      nan_q     <= 1'b0;
      cnt_q     <= '0;
      drain_q   <= '0;
      mac_a     <= 16'h0000;
      mac_b     <= 16'h0000;
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_nan   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      nan_q     <= nan_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      mac_a     <= mac_a_d;
      mac_b     <= mac_b_d;
      mac_en    <= mac_en_d;
      mac_first <= mac_first_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_nan   <= out_nan_d;
      out_cnt   <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_dlfloat_dot_ctrl.sv
// Directed bench for dlfloat_dot_ctrl with a behavioural DLFloat16 MAC (MAC_LAT = 2) attached.
module tb_dlfloat_dot_ctrl;
  localparam int MAC_LAT = 2;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_a = 16'h0;
  logic [15:0]      in_b = 16'h0;
  logic             in_last = 1'b0;
  logic [15:0]      mac_a, mac_b;
  logic             mac_en, mac_first;
  logic [15:0]      mac_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic             out_nan;
  logic [CNT_W-1:0] out_cnt;

  int tests = 0;
  int fails = 0;

  dlfloat_dot_ctrl #(.MAC_LAT(MAC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mac_a(mac_a), .mac_b(mac_b),
    .mac_en(mac_en), .mac_first(mac_first), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nan(out_nan), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: accumulate on the issue edge, one extra register stage to the output.
  function automatic real dl_dec(input logic [15:0] v);
    int  e;
    real r;
    e = int'(v[14:9]);
    if (e == 0) return 0.0;
    r = (1.0 + real'(v[8:0]) / 512.0) * (2.0 ** (e - 31));
    return v[15] ? -r : r;
  endfunction

  function automatic logic [15:0] dl_enc(input real x);
    logic s;
    real  v;
    int   e;
    int   m;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    v = s ? -x : x;
    e = 31;
    while (v >= 2.0 && e < 63) begin v = v / 2.0; e++; end
    while (v < 1.0 && e > 1) begin v = v * 2.0; e--; end
    m = $rtoi((v - 1.0) * 512.0);
    return {s, e[5:0], m[8:0]};
  endfunction

  function automatic logic [15:0] mac_step(input logic first, input logic [15:0] acc,
                                           input logic [15:0] a, input logic [15:0] b);
    if (a == 16'hFFFF || b == 16'hFFFF || (!first && acc == 16'hFFFF)) return 16'hFFFF;
    return dl_enc(dl_dec(a) * dl_dec(b) + (first ? 0.0 : dl_dec(acc)));
  endfunction

  logic [15:0] acc_q, res_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 16'h0;
      res_q <= 16'h0;
    end else begin
      if (mac_en) acc_q <= mac_step(mac_first, acc_q, mac_a, mac_b);
      res_q <= acc_q;
    end
  end
  assign mac_result = res_q;

  // Issue log: number of mac_en pulses and mac_first value per pulse.
  int   en_cnt = 0;
  logic first_log [0:1023];
  always @(posedge clk) begin
    if (mac_en) begin
      first_log[en_cnt % 1024] <= mac_first;
      en_cnt <= en_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last,
                           input logic first, output int waited);
    logic exp_en;
`ifdef DLMAC_ZERO_SKIP_EN
    exp_en = first || (a != 16'h0 && b != 16'h0);
`else
    exp_en = 1'b1;
`endif
    waited = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("mac_en", {31'b0, mac_en}, {31'b0, exp_en});
    check("mac_first", {31'b0, mac_first}, {31'b0, first && exp_en});
    if (exp_en) check("mac_a", {16'b0, mac_a}, {16'b0, a});
  endtask

  task automatic wait_result(input logic [15:0] data, input int cnt, input logic nan);
    int   edges;
    logic ready_seen;
    edges = 0;
    ready_seen = 1'b0;
    while (edges < 40) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      edges++;
      if (out_valid) break;
    end
    check("out_valid", {31'b0, out_valid}, 32'd1);
    check("result_latency", edges, MAC_LAT + 1);
    check("drain_ready_low", {31'b0, ready_seen}, 32'd0);
    check("out_data", {16'b0, out_data}, {16'b0, data});
    check("out_cnt", {24'b0, out_cnt}, cnt);
    check("out_nan", {31'b0, out_nan}, {31'b0, nan});
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_clear", {31'b0, out_valid}, 32'd0);
    check("ready_after_take", {31'b0, in_ready}, 32'd1);
  endtask

  int          w;
  int          en0;
  logic [15:0] held;

  initial begin
    // Reset values
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mac_en", {31'b0, mac_en}, 32'd0);
    check("rst_mac_first", {31'b0, mac_first}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_out_cnt", {24'b0, out_cnt}, 32'd0);
    check("rst_out_nan", {31'b0, out_nan}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready with nothing to deliver is ignored
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_out_ready_valid", {31'b0, out_valid}, 32'd0);
    check("idle_out_ready_in_ready", {31'b0, in_ready}, 32'd1);
    check("idle_mac_en", {31'b0, mac_en}, 32'd0);

    // Basic dot product: 1*2 + 1*2 = 4
    en0 = en_cnt;
    send_beat(16'h3E00, 16'h4000, 1'b0, 1'b1, w);
    send_beat(16'h3E00, 16'h4000, 1'b1, 1'b0, w);
    wait_result(16'h4200, 2, 1'b0);
    check("basic_pulses", en_cnt - en0, 2);
    check("basic_first0", {31'b0, first_log[en0 % 1024]}, 32'd1);
    check("basic_first1", {31'b0, first_log[(en0 + 1) % 1024]}, 32'd0);

    // Backpressure: result held for 5 cycles
    held = out_data;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      check("hold_data", {16'b0, out_data}, {16'b0, held});
      check("hold_cnt", {24'b0, out_cnt}, 32'd2);
      check("hold_ready_low", {31'b0, in_ready}, 32'd0);
    end
    take_out();

    // Single beat, accepted on the edge right after the out_ready edge
    send_beat(16'h3E00, 16'h3E00, 1'b1, 1'b1, w);
    check("accept_after_take", w, 0);
    wait_result(16'h3E00, 1, 1'b0);
    take_out();

    // NaN in the middle beat
    send_beat(16'h3E00, 16'h4000, 1'b0, 1'b1, w);
    send_beat(16'hFFFF, 16'h3E00, 1'b0, 1'b0, w);
    send_beat(16'h3E00, 16'h4000, 1'b1, 1'b0, w);
    wait_result(16'hFFFF, 3, 1'b1);
    take_out();

    // NaN flag cleared for the following vector: 2*2 = 4
    send_beat(16'h4000, 16'h4000, 1'b1, 1'b1, w);
    wait_result(16'h4200, 1, 1'b0);
    take_out();

    // Reset one cycle after the last acceptance
    send_beat(16'h3E00, 16'h4000, 1'b0, 1'b1, w);
    send_beat(16'h3E00, 16'h4000, 1'b1, 1'b0, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_mac_en", {31'b0, mac_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("midrst_no_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_ready", {31'b0, in_ready}, 32'd1);
    end
    send_beat(16'h3E00, 16'h3E00, 1'b1, 1'b1, w);
    wait_result(16'h3E00, 1, 1'b0);
    take_out();

    // Zero operand in the middle beat: 2 + 0 + 2 = 4
    en0 = en_cnt;
    send_beat(16'h3E00, 16'h4000, 1'b0, 1'b1, w);
    send_beat(16'h0000, 16'h4000, 1'b0, 1'b0, w);
    send_beat(16'h3E00, 16'h4000, 1'b1, 1'b0, w);
    wait_result(16'h4200, 3, 1'b0);
`ifdef DLMAC_ZERO_SKIP_EN
    check("zero_pulses", en_cnt - en0, 2);
`else
    check("zero_pulses", en_cnt - en0, 3);
`endif
    take_out();

    // Beat counter saturation: 260 beats of 1*0
    for (int i = 0; i < 260; i++) begin
      send_beat(16'h3E00, 16'h0000, (i == 259), (i == 0), w);
    end
    wait_result(16'h0000, 255, 1'b0);
    take_out();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dlfloat_dot_ctrl.md
# dlfloat_dot_ctrl

Sequencer that runs DLFloat16 dot products on the shared `dlfloat_mac` datapath. It accepts a valid/ready stream of operand pairs grouped into vectors by `in_last`. For each accepted pair it issues one MAC operation, clearing the accumulator on the first beat of each vector. After the last beat it waits out the MAC pipeline and presents the 16-bit result with a valid/ready handshake. It sits between the byte-level I/O wrappers and the MAC core.

## Interface
- `MAC_LAT`, default 2: clock edges the MAC needs after an issue edge before `mac_result` reflects that operation.
- `CNT_W`, default 8: width of the beat counter.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller can accept a pair.
- `in_a`, `in_b`  in  16 each  DLFloat16 operands (sign, 6-bit exponent, 9-bit mantissa; `16'hFFFF` = NaN).
- `in_last`  in  1  final pair of the current vector.
- `mac_a`, `mac_b`  out  16 each  registered operands to the MAC.
- `mac_en`  out  1  issue strobe, one cycle per issued pair.
- `mac_first`  out  1  with `mac_en`: accumulator loads the product instead of adding it.
- `mac_result`  in  16  MAC accumulator output.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  16  dot-product result.
- `out_nan`  out  1  at least one operand in the vector was `16'hFFFF`.
- `out_cnt`  out  `CNT_W`  beats accepted in the vector, saturating at all-ones.

## Operation
- **States:** ACC, DRAIN, HOLD. Reset state is ACC with the internal `first` flag set.
- **Reset values:** all outputs 0, except `in_ready` = 1 (combinational, true only in ACC).
- **ACC, handshake:** a beat is accepted on an edge where `in_valid && in_ready`. On acceptance:
  - `mac_a`/`mac_b` load `in_a`/`in_b`.
  - `mac_en` = 1 for the following cycle.
  - `mac_first` = `first`, then `first` clears.
  - The beat counter increments, saturating.
  - The NaN flag sets if either operand is `16'hFFFF`.
- **ACC, idle cycle:** with no acceptance, `mac_en` and `mac_first` are 0.
- **ACC to DRAIN:** an accepted beat with `in_last` = 1 moves to DRAIN and loads the drain counter with `MAC_LAT`.
- **DRAIN:**
  - If the drain counter is nonzero, decrement it.
  - If it is 0:
    - Capture `mac_result` into `out_data`.
    - Copy the NaN flag to `out_nan`.
    - Copy the beat counter to `out_cnt`.
    - Set `out_valid` = 1 and go to HOLD.
- **HOLD:**
  - `out_valid`, `out_data`, `out_nan` and `out_cnt` are held stable until `out_ready` = 1.
  - On that edge `out_valid` clears, the beat counter and NaN flag clear, `first` sets, and the state returns to ACC.
- **Single-beat vector:** a vector with `in_last` on its first beat is legal; it issues one MAC op with `mac_first` = 1.
- **Beat counter saturation:** sticks at `2^CNT_W-1`; accumulation continues.
- **No backpressure to the MAC:** the MAC always accepts issued operations.

## Timing
- Issue latency: `mac_en` is high in the cycle after the acceptance edge. Back-to-back acceptance gives a continuous `mac_en` stream at one pair per cycle.
- Result latency: if the last beat is accepted on edge T, `out_valid` rises after edge T+MAC_LAT+1. `mac_result` is sampled on that edge.
- Throughput: `in_ready` is low for MAC_LAT+1 cycles in DRAIN, plus 1 or more cycles in HOLD. The first beat of the next vector is accepted no earlier than the edge after the `out_ready` edge.
- `out_ready` high while `out_valid` = 0 has no effect.
- Reset asserted mid-vector or mid-drain: the state returns to ACC immediately with all outputs at reset values. The partial vector is discarded and the next accepted beat carries `mac_first` = 1.

## Configuration
- **`DLMAC_ZERO_SKIP_EN` defined:** an accepted beat with `in_a == 0` or `in_b == 0` is not issued (`mac_en` stays 0), unless it is the first beat of a vector. The first beat is always issued so the accumulator is cleared. Skipped beats still count in `out_cnt`, and a skipped `in_last` beat still enters DRAIN.
- **Undefined:** every accepted beat is issued.

## Test plan
- **Basic dot product:** vector (0x3E00,0x4000),(0x3E00,0x4000) with `in_last` on beat 2 and a MAC model with `MAC_LAT`=2.
  - Required: `mac_en` high 2 cycles, with `mac_first` only on the first.
  - `out_valid` rises 3 edges after the last acceptance, with `out_data`=0x4200, `out_cnt`=2, `out_nan`=0.
- **Single beat:** pair (0x3E00,0x3E00) with `in_last` → one issue with `mac_first`=1; `out_data`=0x3E00, `out_cnt`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in HOLD.
  - Required: outputs stable and `in_ready`=0 throughout.
  - Next vector's first beat accepted 1 edge after the `out_ready` edge, with `mac_first`=1.
- **NaN:** vector of 3 beats with beat 2 `in_a`=0xFFFF → `out_nan`=1; flag cleared for the following vector.
- **Reset mid-drain:** pulse `rst_n` low 1 cycle after the last acceptance.
  - Required: no `out_valid`, `in_ready`=1 after release.
  - Next beat carries `mac_first`=1.
- **Zero skip (`DLMAC_ZERO_SKIP_EN`):** vector (0x3E00,0x4000),(0,0x4000),(0x3E00,0x4000) with last.
  - Required: `mac_en` pulses on beats 1 and 3 only; `out_cnt`=3; `out_data`=0x4200.
  - Without the macro, 3 pulses.
